// File: rtl/sensor_pkg.sv
// Purpose : Shared level codes, valid probe patterns and the pattern encoder
//           used by the reservoir sensor front end.
// Contents: LVL_* level codes, PAT_* valid debounced patterns {high,mid,low},
//           level_state_t (level code + fault flag) and encode_pattern().
package sensor_pkg;

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_LOW   = 2'd1;
    localparam logic [1:0] LVL_MID   = 2'd2;
    localparam logic [1:0] LVL_FULL  = 2'd3;

    localparam logic [2:0] PAT_EMPTY = 3'b000;
    localparam logic [2:0] PAT_LOW   = 3'b001;
    localparam logic [2:0] PAT_MID   = 3'b011;
    localparam logic [2:0] PAT_FULL  = 3'b111;

    typedef struct packed {
        logic [1:0] level;
        logic       err;
    } level_state_t;

    // An impossible pattern (water above a dry probe) raises err and keeps
    // the last trustworthy level rather than guessing a new one.
    function automatic level_state_t encode_pattern(input logic [2:0] pat,
                                                    input logic [1:0] prev);
        level_state_t r;
        r.level = prev;
        r.err   = 1'b1;
        case (pat)
            PAT_EMPTY: begin r.level = LVL_EMPTY; r.err = 1'b0; end
            PAT_LOW:   begin r.level = LVL_LOW;   r.err = 1'b0; end
            PAT_MID:   begin r.level = LVL_MID;   r.err = 1'b0; end
            PAT_FULL:  begin r.level = LVL_FULL;  r.err = 1'b0; end
            default:   begin r.level = prev;      r.err = 1'b1; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/probe_debounce.sv
// Purpose : Two-flop synchroniser plus consecutive-disagreement debouncer for
//           one asynchronous water probe.
// Ports   : clk    - system clock (rising edge)
//           rst    - synchronous active-high reset
//           raw    - asynchronous probe input, 1 = water present
//           stable - debounced probe value
module probe_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any cycle of agreement restarts the count, so only an unbroken
            // run of DEBOUNCE_CYCLES disagreeing samples moves stable.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_level_encoder.sv
// Purpose : Reservoir sensor front end. Debounces the low/mid/high probes and
//           encodes the stable pattern into a level code with a fault flag and
//           a one-cycle change strobe.
// Ports   : clk        - system clock (rising edge)
//           rst        - synchronous active-high reset
//           probe_low  - raw low probe, asynchronous, 1 = water present
//           probe_mid  - raw mid probe, asynchronous, 1 = water present
//           probe_high - raw high probe, asynchronous, 1 = water present
//           level      - last valid level: 0 EMPTY, 1 LOW, 2 MID, 3 FULL
//           level_err  - 1 while the debounced pattern is impossible
//           level_upd  - one-cycle pulse when level or level_err changes
//           probes_dbg - debounced probes {high, mid, low}
module sensor_level_encoder
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       probe_low,
    input  logic       probe_mid,
    input  logic       probe_high,
    output logic [1:0] level,
    output logic       level_err,
    output logic       level_upd,
    output logic [2:0] probes_dbg
);

    logic [2:0]   deb;
    level_state_t nxt;

    probe_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_low (
        .clk   (clk),
        .rst   (rst),
        .raw   (probe_low),
        .stable(deb[0])
    );

    probe_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_mid (
        .clk   (clk),
        .rst   (rst),
        .raw   (probe_mid),
        .stable(deb[1])
    );

    probe_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_high (
        .clk   (clk),
        .rst   (rst),
        .raw   (probe_high),
        .stable(deb[2])
    );

    always_comb begin
        nxt = encode_pattern(deb, level);
    end

    // The strobe compares the incoming pair with the currently registered
    // pair, so it lines up with the cycle the new pair becomes visible. The
    // reset value counts as a genuine previous state.
    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= LVL_EMPTY;
            level_err <= 1'b0;
            level_upd <= 1'b0;
        end else begin
            level     <= nxt.level;
            level_err <= nxt.err;
            level_upd <= (nxt.level != level) || (nxt.err != level_err);
        end
    end

    assign probes_dbg = deb;

endmodule
